ecl_to_ttl_rx: RTL and testbench



---
 rtl/ecl_rx_pkg.sv | 24 ++
 rtl/ecl_rx_channel.sv | 76 +++++++
 rtl/ecl_to_ttl_rx.sv | 59 +++++
 tb/tb_ecl_to_ttl_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecl_rx_pkg.sv
// Shared defaults, counter sizing and per-channel output bundle for the ECL-to-TTL receiver.
package ecl_rx_pkg;

  localparam int unsigned DefWidth       = 6;
  localparam int unsigned DefStretch     = 4;
  localparam int unsigned DefFaultCycles = 3;

  // Wide enough for the full 1..255 range of STRETCH and FAULT_CYCLES.
  localparam int unsigned CntW = 8;

  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic q;
    logic pulse;
    logic hit;
    logic fault;
  } ch_out_t;

  function automatic cnt_t cnt_dec_sat(input cnt_t c);
    return (c == '0) ? '0 : c - cnt_t'(1);
  endfunction

endpackage

// File: rtl/ecl_rx_channel.sv
// One differential receiver channel: 2-flop sync, validity check, level register,
// fault counter, pulse stretcher and sticky hit flag.
module ecl_rx_channel
  import ecl_rx_pkg::*;
#(
  parameter int unsigned STRETCH      = DefStretch,
  parameter int unsigned FAULT_CYCLES = DefFaultCycles
) (
  input  logic    clk_i,
  input  logic    mr_i,
  input  logic    d_i,
  input  logic    dn_i,
  input  logic    rd_i,
  output ch_out_t out_o
);

  localparam cnt_t StretchLoad = cnt_t'(STRETCH);
  localparam cnt_t FaultMax    = cnt_t'(FAULT_CYCLES);
  // {true, complement}: resets to a valid low so release produces no edge.
  localparam logic [1:0] SyncRst = 2'b01;

  logic [1:0] s1_q, s1_d, s2_q, s2_d;
  logic       q_q, q_d;
  logic       hit_q, hit_d;
  cnt_t       fcnt_q, fcnt_d;
  cnt_t       scnt_q, scnt_d;
  logic       ds, dns, valid, rise;

  always_comb begin
    s1_d  = {d_i, dn_i};
    s2_d  = s1_q;
    ds    = s2_q[1];
    dns   = s2_q[0];
    valid = ds ^ dns;
    rise  = valid & ds & ~q_q;

    q_d = valid ? ds : q_q;

    fcnt_d = fcnt_q;
    if (valid) begin
      fcnt_d = '0;
    end else if (fcnt_q != FaultMax) begin
      fcnt_d = fcnt_q + cnt_t'(1);
    end

    // Retrigger reloads, so the pulse extends without a low gap.
    scnt_d = rise ? StretchLoad : cnt_dec_sat(scnt_q);

    // A same-cycle edge beats the read strobe.
    hit_d = rise | (hit_q & ~rd_i);
  end

  always_ff @(posedge clk_i) begin
    if (mr_i) begin
      s1_q   <= SyncRst;
      s2_q   <= SyncRst;
      q_q    <= 1'b0;
      hit_q  <= 1'b0;
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      q_q    <= q_d;
      hit_q  <= hit_d;
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign out_o.q     = q_q;
  assign out_o.pulse = (scnt_q != '0);
  assign out_o.hit   = hit_q;
  assign out_o.fault = (fcnt_q == FaultMax);

endmodule

// File: rtl/ecl_to_ttl_rx.sv
// Registered ECL-to-TTL receiver: WIDTH independent channels plus the HIT_ANY summary flop.
module ecl_to_ttl_rx
  import ecl_rx_pkg::*;
#(
  parameter int unsigned WIDTH        = DefWidth,
  parameter int unsigned STRETCH      = DefStretch,
  parameter int unsigned FAULT_CYCLES = DefFaultCycles
) (
  input  logic             CLK,
  input  logic             MR,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] D_,
  input  logic             RD,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_,
  output logic [WIDTH-1:0] PULSE,
  output logic [WIDTH-1:0] HIT,
  output logic             HIT_ANY,
  output logic [WIDTH-1:0] FAULT
);

  ch_out_t ch_out [WIDTH];
  logic    hit_any_q, hit_any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    ecl_rx_channel #(
      .STRETCH      (STRETCH),
      .FAULT_CYCLES (FAULT_CYCLES)
    ) u_ch (
      .clk_i (CLK),
      .mr_i  (MR),
      .d_i   (D[i]),
      .dn_i  (D_[i]),
      .rd_i  (RD),
      .out_o (ch_out[i])
    );

    assign Q[i]     = ch_out[i].q;
    assign PULSE[i] = ch_out[i].pulse;
    assign HIT[i]   = ch_out[i].hit;
    assign FAULT[i] = ch_out[i].fault;
  end

  always_comb begin
    hit_any_d = |HIT;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      hit_any_q <= 1'b0;
    end else begin
      hit_any_q <= hit_any_d;
    end
  end

  assign HIT_ANY = hit_any_q;
  assign Q_      = ~Q;

endmodule

// File: tb/tb_ecl_to_ttl_rx.sv
// Scoreboard bench for ecl_to_ttl_rx: stimulus queues cycle-tagged expectations,
// a negedge monitor compares each one when its cycle comes up.
module tb_ecl_to_ttl_rx;

  localparam int SQ = 0, SQN = 1, SPULSE = 2, SHIT = 3, SANY = 4, SFAULT = 5;

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] val;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       mr  = 1'b1;
  logic       rd  = 1'b0;
  logic [5:0] d_in  = 6'h3F;
  logic [5:0] dn_in = 6'h00;
  logic [5:0] q, qn, pulse, hit, fault;
  logic       hit_any;

  int   cycle = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  ecl_to_ttl_rx dut (
    .CLK     (clk),
    .MR      (mr),
    .D       (d_in),
    .D_      (dn_in),
    .RD      (rd),
    .Q       (q),
    .Q_      (qn),
    .PULSE   (pulse),
    .HIT     (hit),
    .HIT_ANY (hit_any),
    .FAULT   (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      SQ:      return {2'b00, q};
      SQN:     return {2'b00, qn};
      SPULSE:  return {2'b00, pulse};
      SHIT:    return {2'b00, hit};
      SANY:    return {7'b0, hit_any};
      default: return {2'b00, fault};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cycle) begin
        total++;
        if (sb[i].cyc < cycle) begin
          bad++;
          $display("FAIL %s: check due at cycle %0d never sampled (now %0d)",
                   sb[i].name, sb[i].cyc, cycle);
        end else if (obs(sb[i].sel) !== sb[i].val) begin
          bad++;
          $display("FAIL %s @cycle %0d: got %h want %h",
                   sb[i].name, cycle, obs(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic exp_at(input int dc, input int sel, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cycle + dc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_span(input int lo, input int hi, input int sel, input logic [7:0] val,
                          input string name);
    for (int k = lo; k <= hi; k++) exp_at(k, sel, val, name);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [5:0] d, input logic [5:0] dn);
    d_in  = d;
    dn_in = dn;
  endtask

  task automatic rd_pulse();
    rd = 1'b1;
    step(1);
    rd = 1'b0;
  endtask

  initial begin
    // Reset held two edges with all channels driven high.
    step(1);
    exp_at(1, SQ, 8'h00, "rst_q");
    exp_at(1, SQN, 8'h3F, "rst_qn");
    exp_at(1, SPULSE, 8'h00, "rst_pulse");
    exp_at(1, SHIT, 8'h00, "rst_hit");
    exp_at(1, SANY, 8'h00, "rst_hit_any");
    exp_at(1, SFAULT, 8'h00, "rst_fault");
    step(1);
    mr = 1'b0;
    exp_at(2, SQ, 8'h00, "rel_q_lat");
    exp_at(3, SQ, 8'h3F, "rel_q");
    exp_at(3, SQN, 8'h00, "rel_qn");
    exp_at(3, SHIT, 8'h3F, "rel_hit");
    exp_at(3, SANY, 8'h00, "rel_any_lag");
    exp_at(4, SANY, 8'h01, "rel_any");
    exp_span(3, 6, SPULSE, 8'h3F, "rel_pulse");
    exp_at(7, SPULSE, 8'h00, "rel_pulse_end");
    step(6);
    rd = 1'b1;
    exp_at(1, SHIT, 8'h00, "rd_clear");
    exp_at(2, SANY, 8'h00, "rd_any_clear");
    step(1);
    rd = 1'b0;
    step(2);

    // Single edge on ch2; the preceding fall must not register an event.
    drive(6'h3B, 6'h04);
    exp_at(3, SQ, 8'h3B, "fall_q");
    exp_at(3, SHIT, 8'h00, "fall_no_hit");
    exp_at(3, SPULSE, 8'h00, "fall_no_pulse");
    step(5);
    drive(6'h3F, 6'h00);
    exp_at(2, SQ, 8'h3B, "edge_q_lat");
    exp_at(3, SQ, 8'h3F, "edge_q");
    exp_at(3, SQN, 8'h00, "edge_qn");
    exp_span(3, 6, SPULSE, 8'h04, "edge_pulse");
    exp_at(7, SPULSE, 8'h00, "edge_pulse_end");
    exp_at(3, SHIT, 8'h04, "edge_hit");
    exp_at(3, SANY, 8'h00, "edge_any_lag");
    exp_at(4, SANY, 8'h01, "edge_any");
    step(9);
    exp_at(1, SHIT, 8'h00, "rd_clear2");
    rd_pulse();
    step(2);

    // Retrigger on ch0: rises two cycles apart.
    drive(6'h3E, 6'h01);
    step(5);
    drive(6'h3F, 6'h00);
    exp_at(2, SPULSE, 8'h00, "retrig_pre");
    exp_span(3, 8, SPULSE, 8'h01, "retrig_pulse");
    exp_at(9, SPULSE, 8'h00, "retrig_end");
    exp_at(3, SHIT, 8'h01, "retrig_hit");
    exp_at(4, SQ, 8'h3E, "retrig_q_fall");
    exp_at(5, SQ, 8'h3F, "retrig_q_rise");
    step(1);
    drive(6'h3E, 6'h01);
    step(1);
    drive(6'h3F, 6'h00);
    step(10);

    // Build HIT=05, then RD coincides with a fresh ch0 edge.
    drive(6'h3A, 6'h05);
    step(5);
    drive(6'h3F, 6'h00);
    exp_at(3, SHIT, 8'h05, "hit_05");
    step(6);
    drive(6'h3E, 6'h01);
    step(5);
    drive(6'h3F, 6'h00);
    exp_at(2, SHIT, 8'h05, "coll_pre");
    exp_at(3, SHIT, 8'h01, "coll_hit");
    exp_at(4, SANY, 8'h01, "coll_any");
    step(2);
    rd_pulse();
    step(6);

    // Differential fault on ch5 while Q[5]=0: both lines high.
    drive(6'h1F, 6'h20);
    exp_at(3, SQ, 8'h1F, "flt_pre_q");
    step(5);
    drive(6'h3F, 6'h20);
    exp_span(3, 4, SFAULT, 8'h00, "flt_count");
    exp_span(5, 7, SFAULT, 8'h20, "flt_set");
    exp_at(5, SQ, 8'h1F, "flt_q_hold");
    exp_at(7, SQ, 8'h1F, "flt_q_hold2");
    exp_at(5, SHIT, 8'h01, "flt_no_hit");
    step(8);
    drive(6'h3F, 6'h00);
    exp_at(2, SFAULT, 8'h20, "flt_still");
    exp_at(3, SFAULT, 8'h00, "flt_clear");
    exp_at(2, SQ, 8'h1F, "flt_q_lat");
    exp_at(3, SQ, 8'h3F, "flt_q_follow");
    exp_at(3, SHIT, 8'h21, "flt_hit");
    step(6);

    // MR during PULSE[1] with count 2.
    exp_at(1, SHIT, 8'h00, "rd_clear3");
    rd_pulse();
    drive(6'h3D, 6'h02);
    step(5);
    drive(6'h3F, 6'h00);
    exp_span(3, 5, SPULSE, 8'h02, "mr_pulse");
    exp_at(3, SHIT, 8'h02, "mr_hit");
    step(5);
    mr = 1'b1;
    exp_at(1, SPULSE, 8'h00, "mr_pulse_clr");
    exp_at(1, SHIT, 8'h00, "mr_hit_clr");
    exp_at(1, SQ, 8'h00, "mr_q_clr");
    exp_at(1, SQN, 8'h3F, "mr_qn");
    exp_at(1, SANY, 8'h00, "mr_any_clr");
    exp_at(1, SFAULT, 8'h00, "mr_fault");
    step(1);
    mr = 1'b0;
    exp_at(2, SHIT, 8'h00, "post_mr_lat");
    exp_at(3, SQ, 8'h3F, "post_mr_q");
    exp_at(3, SHIT, 8'h3F, "post_mr_hit");
    exp_span(3, 6, SPULSE, 8'h3F, "post_mr_pulse");
    exp_span(7, 8, SPULSE, 8'h00, "post_mr_once");
    exp_at(4, SANY, 8'h01, "post_mr_any");
    exp_at(8, SHIT, 8'h3F, "post_mr_hold");
    step(12);

    // RD with no hits pending leaves everything quiet.
    exp_at(1, SHIT, 8'h00, "rd_clear4");
    exp_at(1, SQ, 8'h3F, "rd_q_keep");
    rd_pulse();
    exp_at(1, SHIT, 8'h00, "rd_idle_hit");
    exp_at(2, SANY, 8'h00, "rd_idle_any");
    exp_at(1, SPULSE, 8'h00, "rd_idle_pulse");
    rd_pulse();
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
